layer_scheduler: RTL and testbench
==================================

# layer_scheduler

Sequencing controller that time-multiplexes one shared multiply-accumulate/activation datapath across all `NUM_NEURONS` neurons of a layer. It walks a neuron index and an input/weight index and issues the bias-load, accumulate, activate and store strobes the datapath needs, accounting for the one-cycle read latency of the parameter ROM. It sits between the upstream layer (`inputs_ready`) and the downstream layer (`outputs_valid`/`outputs_taken` handshake).

## Interface

Parameters:
- `NUM_INPUTS`, 16, inputs per neuron (≥1, need not be a power of two).
- `NUM_NEURONS`, 8, neurons sharing the datapath (≥1).

Ports:
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `inputs_ready`  in  1  upstream inputs valid; sampled only in `IDLE` (or `DONE` with `outputs_taken`). The input vector must stay stable while `busy`.
- `outputs_taken`  in  1  downstream has consumed the output vector.
- `busy`  out  1  high in every state except `IDLE`.
- `neuron_num`  out  NW  current neuron, selects the parameter ROM bank. NW = max(1, $clog2(NUM_NEURONS)).
- `weight_num`  out  IW  ROM read address issued this cycle. IW = max(1, $clog2(NUM_INPUTS)).
- `mac_input_num`  out  IW  input index whose weight is on the ROM output this cycle; selects `inputs[]`.
- `load_bias`  out  1  accumulator ← bias.
- `accumulate`  out  1  accumulator += inputs[mac_input_num] × weight.
- `activate`  out  1  activation stage samples the accumulator.
- `store`  out  1  write the activated value to output slot `neuron_num`.
- `outputs_valid`  out  1  output vector complete; held until `outputs_taken`.

Reset value of every output is 0.

## Operation

States: `IDLE`, `BIAS`, `MAC`, `ACTIVATE`, `STORE`, `DONE`.
- `IDLE`: all strobes 0, counters 0. On `inputs_ready` → `BIAS`, with `neuron_num` = 0.
- `BIAS`: `load_bias`=1, `weight_num`=0. → `MAC`.
- `MAC` (NUM_INPUTS cycles, k = 0..NUM_INPUTS-1):
  - `accumulate`=1, `mac_input_num`=k.
  - `weight_num`=k+1, forced to 0 when k = NUM_INPUTS-1.
  - At k = NUM_INPUTS-1 → `ACTIVATE`.
- `ACTIVATE`: `activate`=1. → `STORE`.
- `STORE`: `store`=1 with the current `neuron_num`.
  - If `neuron_num` = NUM_NEURONS-1 → `DONE`.
  - Otherwise `neuron_num`+1, → `BIAS`.
- `DONE`: `outputs_valid`=1.
  - `outputs_taken`=1 alone → `IDLE`, with `neuron_num` cleared.
  - `outputs_taken`=1 and `inputs_ready`=1 → `BIAS` for neuron 0 (back-to-back batch).
  - Otherwise hold.

Rules:
- Counters use explicit terminal compares (`== N-1`), never natural wrap, so non-power-of-two counts work.
- NUM_INPUTS=1 gives one `MAC` cycle. NUM_NEURONS=1 goes `STORE` → `DONE`.
- `inputs_ready` in any other state is ignored. No queuing.
- Strobes are mutually exclusive. At most one is high per cycle.
- `reset` asserted in any state: next cycle is `IDLE`, all outputs 0, counters 0. A partial accumulation is discarded.

## Timing

- Per neuron: NUM_INPUTS+3 cycles (`BIAS` + NUM_INPUTS × `MAC` + `ACTIVATE` + `STORE`).
- `inputs_ready` sampled in cycle 0 → `load_bias` in cycle 1.
- `outputs_valid` first high at cycle NUM_NEURONS×(NUM_INPUTS+3)+1.
- ROM read latency is exactly one cycle. The address in cycle t is the weight for `accumulate` in cycle t+1, and `mac_input_num` equals the previous `weight_num`.
- All outputs are registered-state decodes. No combinational path from inputs to outputs except via the state register.

## Structure

- Shared package:
  - `layer_state_t` enum (3-bit).
  - Width helper function `index_width(n)` returning max(1, $clog2(n)).
- Sub-module `index_counter #(COUNT)`:
  - Ports: `clock`, `reset`, `clear`, `enable`; outputs `count` and `terminal` (count == COUNT-1).
  - Instantiated twice, once for neurons and once for inputs.
- `mac_input_num` is a one-cycle delayed copy of `weight_num`, held in a register in the scheduler.

## Test plan

- NUM_INPUTS=4, NUM_NEURONS=3; pulse `inputs_ready`, keep `outputs_taken`=0:
  - 3 groups of `load_bias`, 4×`accumulate` with `mac_input_num` 0,1,2,3, `activate`, `store` with `neuron_num` 0,1,2.
  - `outputs_valid` first high at cycle 22 and held until taken.
- NUM_INPUTS=3, NUM_NEURONS=5 (non-power-of-two): `weight_num` sequence per neuron is 0,1,2,0; `neuron_num` never reaches 5; 30 busy cycles.
- In `DONE`, assert `outputs_taken` and `inputs_ready` together: next cycle is `load_bias` with `neuron_num`=0, `outputs_valid`=0.
- Assert `reset` during neuron 1, `MAC` k=2: next cycle all outputs 0 and state `IDLE`; a following `inputs_ready` restarts at neuron 0, k=0.
- Pulse `inputs_ready` mid-`MAC` and again in `DONE` without `outputs_taken`: no effect on the sequence or counters.
- NUM_INPUTS=1, NUM_NEURONS=1: sequence `load_bias`, `accumulate` (`mac_input_num`=0), `activate`, `store`, then `outputs_valid` at cycle 5.

Source files
------------

// File: rtl/layer_scheduler_pkg.sv
// rtl/layer_scheduler_pkg.sv - shared state encoding and index width helper for the layer scheduler
package layer_scheduler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_BIAS     = 3'd1,
        ST_MAC      = 3'd2,
        ST_ACTIVATE = 3'd3,
        ST_STORE    = 3'd4,
        ST_DONE     = 3'd5
    } layer_state_t;

    // A count of one still needs a one-bit index so ports never collapse to zero width.
    function automatic int index_width(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/index_counter.sv
// rtl/index_counter.sv - modulo-COUNT index counter with explicit terminal compare
module index_counter
    import layer_scheduler_pkg::*;
#(
    parameter int COUNT = 4,
    localparam int W = index_width(COUNT)
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clear,
    input  logic         enable,
    output logic [W-1:0] count,
    output logic         terminal
);

    localparam logic [W-1:0] LAST = W'(COUNT - 1);

    assign terminal = (count == LAST);

    // Wrap on the terminal compare so non-power-of-two counts never overrun.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= terminal ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/layer_scheduler.sv
// rtl/layer_scheduler.sv - sequences bias/MAC/activate/store over all neurons of a layer
module layer_scheduler
    import layer_scheduler_pkg::*;
#(
    parameter int NUM_INPUTS  = 16,
    parameter int NUM_NEURONS = 8,
    localparam int NW = index_width(NUM_NEURONS),
    localparam int IW = index_width(NUM_INPUTS)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          inputs_ready,
    input  logic          outputs_taken,
    output logic          busy,
    output logic [NW-1:0] neuron_num,
    output logic [IW-1:0] weight_num,
    output logic [IW-1:0] mac_input_num,
    output logic          load_bias,
    output logic          accumulate,
    output logic          activate,
    output logic          store,
    output logic          outputs_valid
);

    layer_state_t  state;
    layer_state_t  state_next;

    logic [IW-1:0] in_count;
    logic          in_terminal;
    logic [NW-1:0] nr_count;
    logic          nr_terminal;

    logic          in_clear;
    logic          in_enable;
    logic          nr_clear;
    logic          nr_enable;

    // The input counter only runs inside MAC; the neuron index holds through DONE
    // so the last stored slot stays visible until the output vector is taken.
    assign in_enable = (state == ST_MAC);
    assign in_clear  = (state != ST_MAC);
    assign nr_enable = (state == ST_STORE) && !nr_terminal;
    assign nr_clear  = (state == ST_DONE) && outputs_taken;

    index_counter #(
        .COUNT (NUM_INPUTS)
    ) u_input_counter (
        .clock    (clock),
        .reset    (reset),
        .clear    (in_clear),
        .enable   (in_enable),
        .count    (in_count),
        .terminal (in_terminal)
    );

    index_counter #(
        .COUNT (NUM_NEURONS)
    ) u_neuron_counter (
        .clock    (clock),
        .reset    (reset),
        .clear    (nr_clear),
        .enable   (nr_enable),
        .count    (nr_count),
        .terminal (nr_terminal)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (inputs_ready) begin
                    state_next = ST_BIAS;
                end
            end
            ST_BIAS: begin
                state_next = ST_MAC;
            end
            ST_MAC: begin
                if (in_terminal) begin
                    state_next = ST_ACTIVATE;
                end
            end
            ST_ACTIVATE: begin
                state_next = ST_STORE;
            end
            ST_STORE: begin
                state_next = nr_terminal ? ST_DONE : ST_BIAS;
            end
            ST_DONE: begin
                if (outputs_taken) begin
                    state_next = inputs_ready ? ST_BIAS : ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Prefetch the next weight one cycle ahead of its accumulate; the last MAC
    // cycle parks the address at zero ready for the next neuron's first weight.
    always_comb begin
        busy          = (state != ST_IDLE);
        weight_num    = '0;
        load_bias     = 1'b0;
        accumulate    = 1'b0;
        activate      = 1'b0;
        store         = 1'b0;
        outputs_valid = 1'b0;
        case (state)
            ST_BIAS: begin
                load_bias = 1'b1;
            end
            ST_MAC: begin
                accumulate = 1'b1;
                weight_num = in_terminal ? '0 : in_count + 1'b1;
            end
            ST_ACTIVATE: begin
                activate = 1'b1;
            end
            ST_STORE: begin
                store = 1'b1;
            end
            ST_DONE: begin
                outputs_valid = 1'b1;
            end
            default: begin
                busy = (state != ST_IDLE);
            end
        endcase
    end

    assign neuron_num = nr_count;

    // ROM output lags its address by one cycle, so the input select follows it.
    always_ff @(posedge clock) begin
        if (reset) begin
            mac_input_num <= '0;
        end else begin
            mac_input_num <= weight_num;
        end
    end

endmodule

// File: tb/tb_layer_scheduler.sv
// tb/tb_layer_scheduler.sv - randomized self-checking bench for layer_scheduler in three sizes
module tb_layer_scheduler;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] ir    = '0;
    logic [2:0] ot    = '0;

    int nchecks = 0;
    int nerrors = 0;

    int NI_TAB [3] = '{4, 3, 1};
    int NN_TAB [3] = '{3, 5, 1};

    always #5 clock = ~clock;

    logic       b0, lb0, ac0, at0, st0, ov0;
    logic [1:0] nn0, wn0, mi0;
    logic       b1, lb1, ac1, at1, st1, ov1;
    logic [2:0] nn1;
    logic [1:0] wn1, mi1;
    logic       b2, lb2, ac2, at2, st2, ov2;
    logic [0:0] nn2, wn2, mi2;

    layer_scheduler #(.NUM_INPUTS(4), .NUM_NEURONS(3)) u0 (
        .clock(clock), .reset(reset), .inputs_ready(ir[0]), .outputs_taken(ot[0]),
        .busy(b0), .neuron_num(nn0), .weight_num(wn0), .mac_input_num(mi0),
        .load_bias(lb0), .accumulate(ac0), .activate(at0), .store(st0), .outputs_valid(ov0)
    );

    layer_scheduler #(.NUM_INPUTS(3), .NUM_NEURONS(5)) u1 (
        .clock(clock), .reset(reset), .inputs_ready(ir[1]), .outputs_taken(ot[1]),
        .busy(b1), .neuron_num(nn1), .weight_num(wn1), .mac_input_num(mi1),
        .load_bias(lb1), .accumulate(ac1), .activate(at1), .store(st1), .outputs_valid(ov1)
    );

    layer_scheduler #(.NUM_INPUTS(1), .NUM_NEURONS(1)) u2 (
        .clock(clock), .reset(reset), .inputs_ready(ir[2]), .outputs_taken(ot[2]),
        .busy(b2), .neuron_num(nn2), .weight_num(wn2), .mac_input_num(mi2),
        .load_bias(lb2), .accumulate(ac2), .activate(at2), .store(st2), .outputs_valid(ov2)
    );

    // Packed view: {busy, load_bias, accumulate, activate, store, outputs_valid, neuron, weight, mac_input}
    function automatic logic [29:0] pack(bit b, bit lb, bit ac, bit at, bit st, bit ov,
                                         int nn, int wn, int mi);
        return {b, lb, ac, at, st, ov, 8'(nn), 8'(wn), 8'(mi)};
    endfunction

    function automatic logic [29:0] obs(int d);
        case (d)
            0:       return {b0, lb0, ac0, at0, st0, ov0, 8'(nn0), 8'(wn0), 8'(mi0)};
            1:       return {b1, lb1, ac1, at1, st1, ov1, 8'(nn1), 8'(wn1), 8'(mi1)};
            default: return {b2, lb2, ac2, at2, st2, ov2, 8'(nn2), 8'(wn2), 8'(mi2)};
        endcase
    endfunction

    function automatic int total(int d);
        return NN_TAB[d] * (NI_TAB[d] + 3);
    endfunction

    // Expected outputs at position p of a batch (p = 0 is the first load_bias cycle).
    function automatic logic [29:0] exp_run(int d, int p);
        int ni, per, n, r, k;
        ni  = NI_TAB[d];
        per = ni + 3;
        n   = p / per;
        r   = p % per;
        if (r == 0) return pack(1, 1, 0, 0, 0, 0, n, 0, 0);
        if (r <= ni) begin
            k = r - 1;
            return pack(1, 0, 1, 0, 0, 0, n, (k == ni - 1) ? 0 : k + 1, k);
        end
        if (r == ni + 1) return pack(1, 0, 0, 1, 0, 0, n, 0, 0);
        return pack(1, 0, 0, 0, 1, 0, n, 0, 0);
    endfunction

    function automatic logic [29:0] exp_done(int d);
        return pack(1, 0, 0, 0, 0, 1, NN_TAB[d] - 1, 0, 0);
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic start_batch(int d);
        ir[d] = 1'b1;
        step();
        ir[d] = 1'b0;
    endtask

    // Checks positions p0..p1-1, leaving the bench observing position p1.
    task automatic run_body(int d, int p0, int p1, bit noise, string tag);
        logic [29:0] got, want;
        for (int p = p0; p < p1; p++) begin
            got  = obs(d);
            want = exp_run(d, p);
            nchecks++;
            if (got !== want) begin
                nerrors++;
                $display("FAIL %s dut%0d p=%0d: got %h expected %h", tag, d, p, got, want);
            end
            ir[d] = noise ? 1'($urandom % 2) : 1'b0;
            step();
        end
        ir[d] = 1'b0;
    endtask

    task automatic hold_done(int d, int hold, bit noise, string tag);
        logic [29:0] got;
        for (int i = 0; i <= hold; i++) begin
            got = obs(d);
            nchecks++;
            if (got !== exp_done(d)) begin
                nerrors++;
                $display("FAIL %s_done dut%0d i=%0d: got %h expected %h", tag, d, i, got, exp_done(d));
            end
            if (i < hold) begin
                ir[d] = noise ? 1'($urandom % 2) : 1'b0;
                ot[d] = 1'b0;
                step();
            end
        end
        ir[d] = 1'b0;
    endtask

    task automatic take_outputs(int d, bit b2b, string tag);
        logic [29:0] got, want;
        ot[d] = 1'b1;
        ir[d] = b2b;
        step();
        ot[d] = 1'b0;
        ir[d] = 1'b0;
        got  = obs(d);
        want = b2b ? exp_run(d, 0) : '0;
        nchecks++;
        if (got !== want) begin
            nerrors++;
            $display("FAIL %s_take dut%0d: got %h expected %h", tag, d, got, want);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        for (int d = 0; d < 3; d++) begin
            nchecks++;
            if (obs(d) !== 30'h0) begin
                nerrors++;
                $display("FAIL reset_state dut%0d: got %h expected 0", d, obs(d));
            end
        end
        reset = 1'b0;
        step();
        for (int d = 0; d < 3; d++) begin
            nchecks++;
            if (obs(d) !== 30'h0) begin
                nerrors++;
                $display("FAIL idle_after_reset dut%0d: got %h expected 0", d, obs(d));
            end
        end
    endtask

    task automatic test_basic_sequence();
        start_batch(0);
        run_body(0, 0, total(0), 1'b0, "basic");
        hold_done(0, 3, 1'b0, "basic");
        take_outputs(0, 1'b0, "basic");
    endtask

    // Cycle 0 is the cycle inputs_ready is sampled; count until outputs_valid appears.
    task automatic test_latency(int d);
        int cyc;
        int busy_cycles;
        logic [29:0] v;
        ir[d] = 1'b1;
        cyc = 0;
        busy_cycles = 0;
        v = obs(d);
        while (v[24] !== 1'b1 && cyc < 200) begin
            step();
            ir[d] = 1'b0;
            cyc++;
            v = obs(d);
            if (v[29] === 1'b1 && v[24] !== 1'b1) busy_cycles++;
        end
        nchecks++;
        if (cyc != total(d) + 1) begin
            nerrors++;
            $display("FAIL first_valid_cycle dut%0d: got %0d expected %0d", d, cyc, total(d) + 1);
        end
        nchecks++;
        if (busy_cycles != total(d)) begin
            nerrors++;
            $display("FAIL busy_cycles dut%0d: got %0d expected %0d", d, busy_cycles, total(d));
        end
        hold_done(d, 1, 1'b0, "latency");
        take_outputs(d, 1'b0, "latency");
    endtask

    task automatic test_non_pow2();
        start_batch(1);
        run_body(1, 0, total(1), 1'b0, "nonpow2");
        hold_done(1, 2, 1'b0, "nonpow2");
        take_outputs(1, 1'b0, "nonpow2");
    endtask

    task automatic test_back_to_back();
        start_batch(1);
        run_body(1, 0, total(1), 1'b0, "b2b_first");
        hold_done(1, 2, 1'b0, "b2b_first");
        take_outputs(1, 1'b1, "b2b");
        step();
        run_body(1, 1, total(1), 1'b0, "b2b_second");
        hold_done(1, 0, 1'b0, "b2b_second");
        take_outputs(1, 1'b0, "b2b_second");
    endtask

    task automatic test_reset_midrun();
        int p_mid;
        p_mid = 1 * (NI_TAB[0] + 3) + 1 + 2;
        start_batch(0);
        run_body(0, 0, p_mid, 1'b0, "midrun");
        nchecks++;
        if (obs(0) !== exp_run(0, p_mid)) begin
            nerrors++;
            $display("FAIL midrun_point: got %h expected %h", obs(0), exp_run(0, p_mid));
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        nchecks++;
        if (obs(0) !== 30'h0) begin
            nerrors++;
            $display("FAIL midrun_reset: got %h expected 0", obs(0));
        end
        start_batch(0);
        run_body(0, 0, total(0), 1'b0, "midrun_restart");
        hold_done(0, 0, 1'b0, "midrun_restart");
        take_outputs(0, 1'b0, "midrun_restart");
    endtask

    task automatic test_ignored_inputs();
        start_batch(1);
        run_body(1, 0, total(1), 1'b1, "ignore");
        hold_done(1, 6, 1'b1, "ignore");
        take_outputs(1, 1'b0, "ignore");
    endtask

    task automatic test_single();
        start_batch(2);
        run_body(2, 0, total(2), 1'b0, "single");
        hold_done(2, 2, 1'b0, "single");
        take_outputs(2, 1'b0, "single");
    endtask

    task automatic test_random();
        int d, hold, gap;
        bit noise, b2b;
        for (int it = 0; it < 8; it++) begin
            d     = int'($urandom % 3);
            noise = 1'($urandom % 2);
            b2b   = 1'($urandom % 2);
            hold  = int'($urandom_range(0, 5));
            gap   = int'($urandom_range(0, 3));
            for (int g = 0; g < gap; g++) step();
            start_batch(d);
            run_body(d, 0, total(d), noise, "random");
            hold_done(d, hold, noise, "random");
            take_outputs(d, b2b, "random");
            if (b2b) begin
                step();
                run_body(d, 1, total(d), noise, "random_b2b");
                hold_done(d, 0, 1'b0, "random_b2b");
                take_outputs(d, 1'b0, "random_b2b");
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_sequence();
        test_latency(0);
        test_latency(1);
        test_latency(2);
        test_non_pow2();
        test_back_to_back();
        test_reset_midrun();
        test_ignored_inputs();
        test_single();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
